axo_mem_arbiter: RTL and testbench
==================================

AXO_MEM_ARBITER -- requirements
Module: axo_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the number of cycles a granted transfer may wait on slave ready before it is aborted (range 1..255).
REQ-002 SHALL have ports: clk  in  1  single clock, all state updates on the rising edge.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have data-requester ports: d_re in 1 read; d_we in 1 write; d_asize in 2 access size (0=byte, 1=half, 2=word); d_addr in 32 byte address; d_wdata in 32; d_rdata out 32; d_ready out 1; d_err out 1.
REQ-005 SHALL have fetch-requester ports: p_re in 1 read; p_addr in 31 halfword address [31:1]; p_rdata out 32; p_ready out 1; p_err out 1.
REQ-006 SHALL have slave ports: m_re out 1; m_we out 1; m_asize out 2; m_addr out 32; m_wdata out 32; m_rdata in 32; m_ready in 1.

Function
REQ-007 SHALL implement an FSM with states IDLE, OWN_D and OWN_P.
REQ-008 In IDLE, SHALL arbitrate combinationally among pending requests (d_re|d_we, p_re) and drive the winner onto the slave port in the same cycle, giving zero added latency.
REQ-009 In IDLE, if the winner sees m_ready=1 in that cycle, SHALL complete the transfer in that cycle and remain in IDLE.
REQ-010 In IDLE, if the winner sees m_ready=0, SHALL move to OWN_D or OWN_P and lock the slave to that requester.
REQ-011 In OWN_x, SHALL forward only requester x to the slave and return to IDLE in the cycle after m_ready=1.
REQ-012 In OWN_x, if requester x deasserts its request, SHALL return to IDLE without asserting x_ready.
REQ-013 SHALL pass m_ready combinationally to the granted requester's x_ready and hold the non-granted x_ready at 0.
REQ-014 SHALL drive m_rdata onto both d_rdata and p_rdata; the data is valid only with the matching x_ready.
REQ-015 SHALL map a fetch onto the slave as m_addr={p_addr,1'b0}, m_asize=2, m_we=0.
REQ-016 If both d_re and d_we are asserted, SHALL treat the request as a write.
REQ-017 With no grant, SHALL drive m_re=0, m_we=0, m_addr=0, m_wdata=0 and m_asize=0.
REQ-018 SHALL maintain an 8-bit wait counter that clears on entry to OWN_x and increments each cycle in OWN_x while m_ready=0.
REQ-019 When the wait counter reaches TIMEOUT, SHALL assert x_ready=1 and x_err=1 for one cycle, deassert m_re and m_we that cycle, and return to IDLE.
REQ-020 SHALL drive x_err=0 at all times other than the timeout cycle of REQ-019.

Reset
REQ-021 On rst_n=0, SHALL immediately enter IDLE, clear the wait counter and reset the priority pointer to data.
REQ-022 SHALL, during reset, drive every output to 0 except the combinational pass-through data buses.
REQ-023 If rst_n asserts during an OWN_x transfer, SHALL abandon the transfer and return no ready or err to the requester.

Configuration
REQ-024 With AXO_ARB_ROUND_ROBIN_EN defined, SHALL arbitrate round-robin: a 1-bit pointer flips to favour the other requester after each completed or timed-out transfer.
REQ-025 Without AXO_ARB_ROUND_ROBIN_EN, SHALL use fixed priority with data always winning over fetch, and SHALL not implement the pointer register.

Structure
REQ-026 SHALL place the state enum (IDLE/OWN_D/OWN_P) and the asize encodings (ASIZE_BYTE/HALF/WORD) in shared package axo_mem_pkg.
REQ-027 SHALL isolate the priority logic in sub-module axo_arb_pick2, which takes two requests and a pointer and returns a one-hot grant.

Verification
REQ-028 Bench: p_re=1, p_addr=0x40, m_ready=1 -> same cycle m_re=1, m_addr=0x80, m_asize=2, p_ready=1.
REQ-029 Bench: d_we=1 and p_re=1 simultaneously, m_ready=1 -> data granted first.
  - without the macro: fetch granted next cycle.
  - with the macro: grants alternate d,p,d,p over 4 cycles.
REQ-030 Bench: d_re=1, m_ready low 3 cycles then high -> state OWN_D for 3 cycles; p_re asserted meanwhile is ignored until the cycle after d_ready=1.
REQ-031 Bench: TIMEOUT=4, p_re=1, m_ready stuck 0 -> p_ready=1 and p_err=1 exactly 4 cycles after entering OWN_P, then IDLE.
REQ-032 Bench: rst_n pulled low in OWN_D -> all outputs 0 asynchronously; after release, state IDLE and d_ready stays 0 for the abandoned transfer.

Source files
------------

// File: rtl/axo_mem_pkg.sv
// Shared types for the AXO memory arbiter: FSM state, access-size codes and the
// slave-side request bundle with the helpers that build it.
package axo_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_D = 2'd1,
    OWN_P = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    ASIZE_BYTE = 2'd0,
    ASIZE_HALF = 2'd1,
    ASIZE_WORD = 2'd2
  } asize_e;

  localparam int unsigned WaitCntW = 8;

  typedef struct packed {
    logic        re;
    logic        we;
    logic [1:0]  asize;
    logic [31:0] addr;
    logic [31:0] wdata;
  } slv_req_t;

  // A combined read+write request is issued as a write.
  function automatic slv_req_t data_req(logic re, logic we, logic [1:0] asize,
                                        logic [31:0] addr, logic [31:0] wdata);
    slv_req_t r;
    r.re    = re & ~we;
    r.we    = we;
    r.asize = asize;
    r.addr  = addr;
    r.wdata = wdata;
    return r;
  endfunction

  // Fetches are always word reads at the halfword-aligned address.
  function automatic slv_req_t fetch_req(logic [30:0] haddr);
    slv_req_t r;
    r.re    = 1'b1;
    r.we    = 1'b0;
    r.asize = ASIZE_WORD;
    r.addr  = {haddr, 1'b0};
    r.wdata = '0;
    return r;
  endfunction

endpackage

// File: rtl/axo_arb_pick2.sv
// Two-way priority picker: ptr=0 favours the data requester, ptr=1 the fetch
// requester. Grant is one-hot ({fetch, data}) or zero when nothing is pending.
module axo_arb_pick2 (
  input  logic       req_d,
  input  logic       req_p,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req_d && (!ptr || !req_p)) begin
      gnt[0] = 1'b1;
    end else if (req_p) begin
      gnt[1] = 1'b1;
    end
  end

endmodule

// File: rtl/axo_mem_arbiter.sv
// Arbitrates a data port and an instruction-fetch port onto one memory slave.
// Define AXO_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed data-first.
module axo_mem_arbiter
  import axo_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  // data requester
  input  logic        d_re,
  input  logic        d_we,
  input  logic [1:0]  d_asize,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_err,
  // fetch requester
  input  logic        p_re,
  input  logic [30:0] p_addr,
  output logic [31:0] p_rdata,
  output logic        p_ready,
  output logic        p_err,
  // memory slave
  output logic        m_re,
  output logic        m_we,
  output logic [1:0]  m_asize,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready
);

  localparam logic [WaitCntW-1:0] TimeoutCnt = WaitCntW'(TIMEOUT);

  arb_state_e          state_q;
  logic [WaitCntW-1:0] wait_cnt_q;
  logic                ptr;
  logic [1:0]          gnt;
  logic                req_d, req_p;
  logic                sel_d, sel_p, busy;
  logic                timeout, done;
  slv_req_t            slv;

  assign req_d = d_re | d_we;
  assign req_p = p_re;

  axo_arb_pick2 u_pick (
    .req_d (req_d),
    .req_p (req_p),
    .ptr   (ptr),
    .gnt   (gnt)
  );

  // Who drives the slave this cycle: the arbiter winner in IDLE, else only the owner.
  always_comb begin
    sel_d = 1'b0;
    sel_p = 1'b0;
    case (state_q)
      IDLE: begin
        sel_d = gnt[0];
        sel_p = gnt[1];
      end
      OWN_D:   sel_d = req_d;
      OWN_P:   sel_p = req_p;
      default: ;
    endcase
  end

  assign busy    = sel_d | sel_p;
  assign timeout = (state_q != IDLE) && busy && (wait_cnt_q == TimeoutCnt);
  assign done    = busy & (m_ready | timeout);

  always_comb begin
    slv = '0;
    if (sel_d) begin
      slv = data_req(d_re, d_we, d_asize, d_addr, d_wdata);
    end else if (sel_p) begin
      slv = fetch_req(p_addr);
    end
    if (timeout) begin
      slv.re = 1'b0;
      slv.we = 1'b0;
    end
  end

  // Every control/address output is forced low while reset is held.
  assign m_re    = rst_n & slv.re;
  assign m_we    = rst_n & slv.we;
  assign m_asize = rst_n ? slv.asize : 2'b00;
  assign m_addr  = rst_n ? slv.addr : 32'h0;
  assign m_wdata = rst_n ? slv.wdata : 32'h0;

  assign d_ready = rst_n & sel_d & (m_ready | timeout);
  assign p_ready = rst_n & sel_p & (m_ready | timeout);
  assign d_err   = rst_n & sel_d & timeout;
  assign p_err   = rst_n & sel_p & timeout;

  assign d_rdata = m_rdata;
  assign p_rdata = m_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (busy && !m_ready) begin
            state_q    <= sel_d ? OWN_D : OWN_P;
            wait_cnt_q <= '0;
          end
        end
        OWN_D, OWN_P: begin
          // Owner dropped its request, slave answered, or the wait expired.
          if (!busy || done) begin
            state_q <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef AXO_ARB_ROUND_ROBIN_EN
  logic ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (done) begin
      ptr_q <= ~ptr_q;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = 1'b0;
`endif

endmodule

// File: tb/tb_axo_mem_arbiter.sv
// Self-checking bench for axo_mem_arbiter: vector table, directed corner sequences
// and a randomized run against a transaction-level reference model.
module tb_axo_mem_arbiter;

  localparam int unsigned Tmo = 4;
`ifdef AXO_ARB_ROUND_ROBIN_EN
  localparam bit Rr = 1'b1;
`else
  localparam bit Rr = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        d_re, d_we, p_re, m_ready;
  logic [1:0]  d_asize;
  logic [31:0] d_addr, d_wdata, m_rdata;
  logic [30:0] p_addr;
  logic [31:0] d_rdata, p_rdata, m_addr, m_wdata;
  logic        d_ready, d_err, p_ready, p_err, m_re, m_we;
  logic [1:0]  m_asize;

  always #5 clk = ~clk;

  axo_mem_arbiter #(.TIMEOUT(Tmo)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_re    (d_re),
    .d_we    (d_we),
    .d_asize (d_asize),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ready (d_ready),
    .d_err   (d_err),
    .p_re    (p_re),
    .p_addr  (p_addr),
    .p_rdata (p_rdata),
    .p_ready (p_ready),
    .p_err   (p_err),
    .m_re    (m_re),
    .m_we    (m_we),
    .m_asize (m_asize),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ready (m_ready)
  );

  typedef struct packed {
    logic        m_re;
    logic        m_we;
    logic [1:0]  m_asize;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        d_ready;
    logic        d_err;
    logic        p_ready;
    logic        p_err;
  } out_t;

  typedef struct {
    string       name;
    logic        d_re;
    logic        d_we;
    logic [1:0]  d_asize;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        p_re;
    logic [30:0] p_addr;
    logic        m_ready;
    out_t        exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the slave (-1 none, 0 data, 1 fetch), how long it
  // has been stalled, and whether the round-robin turn belongs to fetch.
  int own = -1;
  int waited = 0;
  bit fav_p = 1'b0;

  function automatic out_t mk(logic re, logic we, logic [1:0] sz, logic [31:0] ad,
                              logic [31:0] wd, logic dr, logic de, logic pr, logic pe);
    out_t o;
    o = '{re, we, sz, ad, wd, dr, de, pr, pe};
    return o;
  endfunction

  function automatic out_t actual();
    return mk(m_re, m_we, m_asize, m_addr, m_wdata, d_ready, d_err, p_ready, p_err);
  endfunction

  task automatic check_out(input string name, input out_t exp);
    out_t got;
    got = actual();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (re,we,asize,addr,wdata,drdy,derr,prdy,perr)",
               name, got, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic out_t model_eval(output int winner, output bit fin);
    out_t o;
    bit   want_d, tmo;
    o      = '0;
    want_d = d_re | d_we;
    if (own < 0) begin
      if (want_d && !(Rr && fav_p && p_re)) winner = 0;
      else if (p_re) winner = 1;
      else winner = -1;
    end else begin
      winner = ((own == 0 && want_d) || (own == 1 && p_re)) ? own : -1;
    end
    tmo = (own >= 0) && (winner >= 0) && (waited == int'(Tmo));
    if (winner == 0) begin
      o.m_we    = d_we;
      o.m_re    = d_re & ~d_we;
      o.m_asize = d_asize;
      o.m_addr  = d_addr;
      o.m_wdata = d_wdata;
      o.d_ready = tmo | m_ready;
      o.d_err   = tmo;
    end else if (winner == 1) begin
      o.m_re    = 1'b1;
      o.m_asize = 2'd2;
      o.m_addr  = {p_addr, 1'b0};
      o.p_ready = tmo | m_ready;
      o.p_err   = tmo;
    end
    if (tmo) begin
      o.m_re = 1'b0;
      o.m_we = 1'b0;
    end
    fin = (winner >= 0) && (tmo || m_ready);
    return o;
  endfunction

  task automatic model_step(input int winner, input bit fin);
    if (winner < 0) begin
      own = -1;
    end else if (fin) begin
      own = -1;
      if (Rr) fav_p = ~fav_p;
    end else if (own < 0) begin
      own    = winner;
      waited = 0;
    end else begin
      waited++;
    end
  endtask

  task automatic clear_inputs();
    d_re = 0; d_we = 0; d_asize = 0; d_addr = 0; d_wdata = 0;
    p_re = 0; p_addr = 0; m_ready = 0; m_rdata = 0;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    adv();
    rst_n  = 1'b1;
    own    = -1;
    waited = 0;
    fav_p  = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    int   k, w;
    bit   f;
    out_t e;

    vecs[0] = '{"idle", 0, 0, 2'd0, 32'h0, 32'h0, 0, 31'h0, 1,
                mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[1] = '{"d_rd_byte", 1, 0, 2'd0, 32'h0000_1003, 32'h0, 0, 31'h0, 1,
                mk(1, 0, 0, 32'h0000_1003, 0, 1, 0, 0, 0)};
    vecs[2] = '{"d_wr_half", 0, 1, 2'd1, 32'h0000_2002, 32'h0000_beef, 0, 31'h0, 1,
                mk(0, 1, 1, 32'h0000_2002, 32'h0000_beef, 1, 0, 0, 0)};
    vecs[3] = '{"d_rw_is_write", 1, 1, 2'd2, 32'h0000_3000, 32'h1234_5678, 0, 31'h0, 1,
                mk(0, 1, 2, 32'h0000_3000, 32'h1234_5678, 1, 0, 0, 0)};
    vecs[4] = '{"p_fetch_40", 0, 0, 2'd0, 32'h0, 32'h0, 1, 31'h40, 1,
                mk(1, 0, 2, 32'h0000_0080, 0, 0, 0, 1, 0)};
    vecs[5] = '{"p_fetch_top", 0, 0, 2'd0, 32'h0, 32'h0, 1, 31'h7fff_ffff, 1,
                mk(1, 0, 2, 32'hffff_fffe, 0, 0, 0, 1, 0)};
    vecs[6] = '{"d_wr_byte_top", 0, 1, 2'd0, 32'hffff_ffff, 32'h0000_00a5, 0, 31'h0, 1,
                mk(0, 1, 0, 32'hffff_ffff, 32'h0000_00a5, 1, 0, 0, 0)};

    // Reset state: requests present, yet everything but the data buses stays low.
    rst_n = 1'b0;
    clear_inputs();
    d_we = 1; p_re = 1; m_ready = 1; d_addr = 32'h55; m_rdata = 32'h1234_5678;
    #3;
    check_out("reset_outputs", '0);
    check_val("reset_rdata_pass", d_rdata, 32'h1234_5678);
    adv();
    rst_n = 1'b1;
    clear_inputs();
    adv();

    // Single-cycle transfers from IDLE.
    for (int i = 0; i < 7; i++) begin
      d_re = vecs[i].d_re; d_we = vecs[i].d_we; d_asize = vecs[i].d_asize;
      d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
      p_re = vecs[i].p_re; p_addr = vecs[i].p_addr; m_ready = vecs[i].m_ready;
      m_rdata = 32'h0a0b_0c00 + 32'(i);
      @(negedge clk);
      check_out(vecs[i].name, vecs[i].exp);
      check_val("p_rdata_pass", p_rdata, 32'h0a0b_0c00 + 32'(i));
      adv();
    end

    // Simultaneous data write and fetch: data goes first.
    do_reset();
    d_we = 1; d_asize = 2; d_addr = 32'h10; d_wdata = 32'hcafe; p_re = 1; p_addr = 31'h8;
    m_ready = 1;
    if (Rr) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (i % 2 == 0) check_out("rr_grant_d", mk(0, 1, 2, 32'h10, 32'hcafe, 1, 0, 0, 0));
        else check_out("rr_grant_p", mk(1, 0, 2, 32'h10, 0, 0, 0, 1, 0));
        adv();
      end
    end else begin
      @(negedge clk);
      check_out("both_grant_d", mk(0, 1, 2, 32'h10, 32'hcafe, 1, 0, 0, 0));
      adv();
      d_we = 0;
      @(negedge clk);
      check_out("then_grant_p", mk(1, 0, 2, 32'h10, 0, 0, 0, 1, 0));
      adv();
    end

    // Data stalls three cycles; a fetch arriving meanwhile must wait.
    do_reset();
    d_re = 1; d_asize = 2; d_addr = 32'h300; m_ready = 0;
    @(negedge clk);
    check_out("own_d_enter", mk(1, 0, 2, 32'h300, 0, 0, 0, 0, 0));
    adv();
    p_re = 1; p_addr = 31'h55;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_out("own_d_hold", mk(1, 0, 2, 32'h300, 0, 0, 0, 0, 0));
      adv();
    end
    m_ready = 1;
    @(negedge clk);
    check_out("own_d_done", mk(1, 0, 2, 32'h300, 0, 1, 0, 0, 0));
    adv();
    d_re = 0;
    @(negedge clk);
    check_out("p_after_d", mk(1, 0, 2, 32'h0000_00aa, 0, 0, 0, 1, 0));
    adv();

    // Fetch stuck on a silent slave times out after Tmo cycles in OWN_P.
    do_reset();
    p_re = 1; p_addr = 31'h100; m_ready = 0;
    @(negedge clk);
    check_out("own_p_enter", mk(1, 0, 2, 32'h200, 0, 0, 0, 0, 0));
    adv();
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (p_err === 1'b1) break;
      k++;
      adv();
    end
    check_val("timeout_latency", 32'(k), 32'(Tmo));
    check_out("timeout_cycle", mk(0, 0, 2, 32'h200, 0, 0, 0, 1, 1));
    adv();
    p_re = 0; d_re = 1; d_asize = 0; d_addr = 32'h7; m_ready = 1;
    @(negedge clk);
    check_out("idle_after_tmo", mk(1, 0, 0, 32'h7, 0, 1, 0, 0, 0));
    adv();

    // Reset in the middle of an OWN_D transfer.
    do_reset();
    d_re = 1; d_asize = 2; d_addr = 32'h44; m_ready = 0;
    adv();
    #1;
    rst_n = 1'b0;
    m_ready = 1; m_rdata = 32'hdead_0001;
    #1;
    check_out("async_reset_outs", '0);
    check_val("async_reset_rdata", d_rdata, 32'hdead_0001);
    adv();
    d_re = 0; rst_n = 1'b1;
    own = -1; waited = 0; fav_p = 1'b0;
    @(negedge clk);
    check_out("abandoned_no_ready", '0);
    adv();
    p_re = 1; p_addr = 31'h20;
    @(negedge clk);
    check_out("idle_after_reset", mk(1, 0, 2, 32'h40, 0, 0, 0, 1, 0));
    adv();

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        d_re = 1'($urandom_range(0, 1));
        d_we = 1'($urandom_range(0, 1));
        p_re = 1'($urandom_range(0, 1));
      end
      m_ready = (i < 300) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
      d_asize = 2'($urandom_range(0, 2));
      d_addr  = $urandom;
      d_wdata = $urandom;
      p_addr  = 31'($urandom);
      m_rdata = $urandom;
      @(negedge clk);
      e = model_eval(w, f);
      check_out("random", e);
      check_val("random_rdata", d_rdata, m_rdata);
      model_step(w, f);
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
